// File: rtl/sha256_block_sequencer.sv
// Control sequencer for one SHA-256 block: hash init, 16-word message fetch,
// 64 compression rounds, final hash addition and a completion pulse.
module sha256_block_sequencer #(
    parameter int ADDR_W = 16,
    parameter int WORDS  = 16,
    parameter int ROUNDS = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              word_valid,
    output logic [3:0]        word_index,
    output logic              init_en,
    output logic              round_en,
    output logic [5:0]        round_idx,
    output logic              final_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        ROUND,
        FINAL,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [6:0]        cnt;
    logic [6:0]        cnt_nxt;

    assign cnt_nxt = cnt + 7'd1;

    // Outputs are computed for the state/count being entered, so every
    // output is a flop and no input reaches an output combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            base       <= '0;
            cnt        <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            word_valid <= 1'b0;
            word_index <= '0;
            init_en    <= 1'b0;
            round_en   <= 1'b0;
            round_idx  <= '0;
            final_en   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            word_valid <= 1'b0;
            word_index <= '0;
            init_en    <= 1'b0;
            round_en   <= 1'b0;
            round_idx  <= '0;
            final_en   <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= INIT;
                        base    <= base_addr;
                        cnt     <= '0;
                        init_en <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                INIT: begin
                    state     <= LOAD;
                    cnt       <= '0;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= base;
                end
                LOAD: begin
                    if (cnt == 7'(WORDS)) begin
                        state    <= ROUND;
                        cnt      <= '0;
                        round_en <= 1'b1;
                    end else begin
                        // word_valid trails the read strobe by the memory's 1-cycle latency
                        cnt        <= cnt_nxt;
                        word_valid <= 1'b1;
                        word_index <= cnt[3:0];
                        if (cnt_nxt < 7'(WORDS)) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= base + ADDR_W'(cnt_nxt);
                        end
                    end
                end
                ROUND: begin
                    if (cnt == 7'(ROUNDS - 1)) begin
                        state    <= FINAL;
                        cnt      <= '0;
                        final_en <= 1'b1;
                    end else begin
                        cnt       <= cnt_nxt;
                        round_en  <= 1'b1;
                        round_idx <= cnt_nxt[5:0];
                    end
                end
                FINAL: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sha256_block_sequencer.md
# sha256_block_sequencer

Control sequencer for one 512-bit SHA-256 block compression. On `start` it loads the initial hash registers, fetches 16 message words from a synchronous word memory into the message-schedule registers, and steps the 64 compression rounds. It then commits the final hash addition and pulses `done`. It drives only the enables and indices of the 32-bit datapath registers and the memory address; it carries no data itself.

## Interface

- `ADDR_W`, default 16: word-address width of the message memory.
- `WORDS`, default 16: message words fetched per block; must be 16.
- `ROUNDS`, default 64: compression rounds per block; must be 64.

- `clock`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  request to process one block; sampled only in IDLE.
- `base_addr`  in  ADDR_W  word address of message word 0; latched when `start` is accepted.
- `mem_rd_en`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  memory word address.
- `word_valid`  out  1  memory data for `word_index` is valid this cycle; the datapath captures it into W[`word_index`].
- `word_index`  out  4  W register index, 0..15.
- `init_en`  out  1  load the H0..H7 constants into the working and hash registers.
- `round_en`  out  1  advance the compression datapath by one round.
- `round_idx`  out  6  current round, 0..63; selects K[t] and W[t].
- `final_en`  out  1  add the working registers into the hash registers.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation

- Moore FSM with states IDLE, INIT, LOAD, ROUND, FINAL, DONE. All outputs are registered or decoded from registered state and counters only; no input reaches an output combinationally.
- IDLE: all outputs 0. If `start`=1, latch `base_addr`, clear counters, and go to INIT.
- INIT: `init_en`=1 for exactly 1 cycle, then go to LOAD.
- LOAD: lasts 17 cycles, with cycle counter `lc` running 0..16.
  - For `lc`=0..15: `mem_rd_en`=1 and `mem_addr` = `base_addr_latched` + `lc`, computed mod 2^ADDR_W (wraps, no carry out).
  - For `lc`=1..16: `word_valid`=1 and `word_index` = `lc`-1. This reflects the 1-cycle read latency.
  - At `lc`=16, go to ROUND.
- ROUND: `round_en`=1 for 64 cycles, with `round_idx` running 0..63. After `round_idx`=63, go to FINAL.
- FINAL: `final_en`=1 for 1 cycle, then go to DONE.
- DONE: `done`=1 for 1 cycle, then go to IDLE.
- `start` outside IDLE is ignored and not queued. `start` held high continuously yields back-to-back blocks with one IDLE cycle between them.
- When not qualified by its strobe, each index output holds 0: `mem_addr` is 0 when `mem_rd_en`=0, `word_index` is 0 when `word_valid`=0, and `round_idx` is 0 when `round_en`=0.
- Enable exclusivity: at most one of `init_en`, `round_en`, `final_en`, `done` is high in any cycle. `word_valid` never overlaps `round_en`.

## Timing

- Reset: when `reset`=1 at an edge, the FSM goes to IDLE and every output is 0 from that edge onward. This includes `busy`, `done`, and all indices, and the latched address and counters are cleared.
- Reset in mid-operation aborts the block immediately. No `final_en` or `done` is issued for the aborted block.
- Reset has priority over `start` in the same cycle.
- Latency: with `start` sampled in IDLE at cycle c, the FSM occupies:
  - INIT at c+1;
  - LOAD from c+2 to c+18, with `mem_rd_en` from c+2 to c+17 and `word_valid` from c+3 to c+18;
  - ROUND from c+19 to c+82;
  - FINAL at c+83;
  - DONE at c+84.
- `busy` is high from c+1 to c+84 inclusive.
- Minimum start-to-start period is 85 cycles.
- Memory contract: data for the address presented in cycle t must be valid in cycle t+1.

## Test plan

- Basic block: reset, then `start` pulse with `base_addr`=0x0100 at cycle 10. Required:
  - `init_en` at cycle 11;
  - `mem_addr` 0x0100..0x010F on cycles 12..27;
  - `word_index` 0..15 on cycles 13..28;
  - `round_idx` 0..63 on cycles 29..92;
  - `final_en` at 93 and `done` at 94;
  - `busy` low again at cycle 95.
- Address wrap: `base_addr`=0xFFFA. Required: `mem_addr` sequence 0xFFFA..0xFFFF, then 0x0000..0x0009.
- Start while busy: a second `start` with `base_addr`=0x2000 at cycle 50 of the basic block. Required: ignored, and the block completes with the original addresses and the same timing.
- Back-to-back: `start` held high from cycle 10. Required: `done` at 94, the next `init_en` at 96, and the next `done` at 179.
- Reset mid-operation: assert `reset` when `round_idx`=20, then `start` later. Required:
  - every output 0 on the next cycle, and `final_en` and `done` never pulse for the aborted block;
  - a new `start` afterwards produces the full 84-cycle sequence.
- Exclusivity check: an assertion runs on all of the above. Required: never more than one of `init_en`, `round_en`, `final_en`, `done` high; `word_valid` and `round_en` never both high; `mem_rd_en` only in LOAD.
